tl_tx_arbiter: RTL and testbench
================================

# tl_tx_arbiter

Transmit-side scheduler of the transaction layer. It selects the next TLP among the Posted, Non-Posted and Completion TX queues, checks link credits and retry-buffer space, then sequences the header and payload pops onto the 256-bit TLP stream toward the DLL. It sits between the AXI slave/master TX FIFOs and the DLL `tlp_o`/`req_o` interface, and consumes credit-available counts from flow control.

## Interface
- `MPS_DW`, 32: maximum payload in DW. Sets payload beats ≤ MPS_DW/8.
- `RETRY_DEPTH_LG2`, 8: sets the retry-buffer leftover count width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `link_active_i` in 1: when low, no new TLP is granted.
- `p_hdr_empty_i`/`np_hdr_empty_i`/`cpl_hdr_empty_i` in 1 each: header FIFO empty (FWFT).
- `p_hdr_rdata_i` in 128, `np_hdr_rdata_i` in 128, `cpl_hdr_rdata_i` in 96: head-of-queue header. DW0[9:0] is Length; DW0[30] is has-data.
- `p_data_rdata_i`/`cpl_data_rdata_i` in 256 each: head payload beat (FWFT).
- `p_hdr_rden_o`/`np_hdr_rden_o`/`cpl_hdr_rden_o`/`p_data_rden_o`/`cpl_data_rden_o` out 1 each: pop strobes.
- `p_payload_cnt_i`/`cpl_payload_cnt_i` in 4 each: count of complete payloads buffered.
- `p_sent_o`/`cpl_sent_o` out 1 each: 1-cycle pulse when the last beat of a TLP is popped.
- `ph_avail_i`, `pd_avail_i`, `nh_avail_i`, `ch_avail_i`, `cd_avail_i` in 12 each: credits available. Header credit = 1 per TLP; data credit = ceil(Length/4).
- `retry_leftover_i` in RETRY_DEPTH_LG2+3: free retry-buffer DW.
- `tlp_o` out 256: TLP beat. The header is zero-extended.
- `req_o` out 3: beat code. IDLE=0, P_HDR=1, P_DATA=2, NP_HDR=3, CPL_HDR=5, CPL_DATA=6.

## Operation
- FSM states are IDLE, HDR, DATA.
- **Eligibility.** A class is eligible when all of the following hold: its header FIFO is non-empty; its header credit ≥ 1; its data credit ≥ ceil(Len/4) if has-data; its payload_cnt ≥ 1 if has-data; `retry_leftover_i` ≥ 4 + 8·beats, where beats = ceil(Len/8) and is 0 without data; and `link_active_i` is high. NP is header-only.
- **Arbitration.** Round-robin, evaluated only in IDLE. Order after a grant: P→NP→CPL→P. The pointer advances past the granted class. Ineligible classes are skipped.
- **IDLE→HDR.** On grant, latch the class and the beat count. Assert that class's hdr_rden for one cycle.
- **HDR→DATA** if beats > 0, otherwise HDR→IDLE.
- **DATA.** Assert data_rden once per cycle, `beats` times. On the last beat, pulse sent_o and return to IDLE.
- **Back-to-back.** A new grant may be evaluated in the same cycle the FSM returns to IDLE. Minimum gap is 1 idle cycle per TLP.
- **Length decoding.** Length==0 is treated as 1024 DW. Lengths above MPS_DW are not legal inputs.
- **Mid-TLP changes.** A drop in credits or in `link_active_i` mid-TLP does not abort; the TLP completes.

## Timing
- Registered outputs: `tlp_o`, `req_o`, and `sent_o`.
  - Pop at edge N ⇒ beat on `tlp_o`/`req_o` after edge N+1.
  - Grant-to-first-beat latency is 2 cycles.
- `*_rden_o` are combinational from FSM state and registered class; no combinational path from `*_avail_i`.
- Reset values: all rden 0, `tlp_o` 0, `req_o` IDLE, sent 0, FSM IDLE, RR pointer at P.
- `req_o` returns to IDLE on any cycle with no pop.
- Reset mid-TLP: everything returns to reset values. FIFO recovery is the owner's responsibility.

## Configuration
- `TL_TX_ARB_STRICT_PRIO_EN` defined: fixed priority CPL > P > NP; no pointer.
- Undefined: round-robin as above.

## Structure
- Shared package `tl_pkg`:
  - `req_t` enum (codes above).
  - Header field offsets.
  - `beats_of(len)` and `credits_of(len)` functions.
- One sub-module, `tl_rr_arb3`: 3-way round-robin picker. It takes eligibility and a grant strobe and returns a one-hot grant. In strict mode it becomes a fixed-priority encoder.

## Test plan
- P write, Len=16 DW, pd_avail=4, retry=100 → `req_o` sequence 1,2,2; `p_sent_o` pulses once; pops are 1 hdr and 2 data.
- P, NP and CPL (Len=8) all eligible, 3 rounds → grant order P, NP, CPL repeats. With strict macro: CPL, P, NP.
- P Len=32 with pd_avail=7 → P never granted while NP proceeds. Raising pd_avail to 8 → P granted next IDLE.
- retry_leftover=35 with P Len=32 (needs 36) → stall; 36 → grant.
- CPL without data (Len field 0, has-data=0) → single beat `req_o`=5, no data pop, no `cpl_sent_o`.
- Assert `rst_n` during the 2nd data beat → outputs zero asynchronously; after release FSM is IDLE and the pointer is at P.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared transaction-layer TX types: beat codes, TLP classes, header field offsets and
// length-to-beats/credits helpers.
package tl_pkg;

  typedef enum logic [2:0] {
    ReqIdle    = 3'd0,
    ReqPHdr    = 3'd1,
    ReqPData   = 3'd2,
    ReqNpHdr   = 3'd3,
    ReqCplHdr  = 3'd5,
    ReqCplData = 3'd6
  } req_t;

  typedef enum logic [1:0] {
    ClsP   = 2'd0,
    ClsNp  = 2'd1,
    ClsCpl = 2'd2
  } cls_t;

  localparam int unsigned HdrLenLsb     = 0;
  localparam int unsigned HdrLenW       = 10;
  localparam int unsigned HdrHasDataBit = 30;

  // A Length field of zero encodes the maximum of 1024 DW.
  function automatic logic [10:0] len_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  // 256-bit beats needed for a payload of len DW.
  function automatic logic [7:0] beats_of(input logic [9:0] len);
    logic [10:0] l;
    l = len_dw(len) + 11'd7;
    return l[10:3];
  endfunction

  // Data credits (4 DW each) consumed by a payload of len DW.
  function automatic logic [8:0] credits_of(input logic [9:0] len);
    logic [10:0] l;
    l = len_dw(len) + 11'd3;
    return l[10:2];
  endfunction

endpackage

// File: rtl/tl_rr_arb3.sv
// 3-way TX class picker (bit 0 = P, 1 = NP, 2 = CPL). Round-robin by default; with
// TL_TX_ARB_STRICT_PRIO_EN defined it is a fixed CPL > P > NP priority encoder.
module tl_rr_arb3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] elig,
  input  logic       grant_en,
  output logic [2:0] gnt
);

`ifdef TL_TX_ARB_STRICT_PRIO_EN
  always_comb begin
    gnt = 3'b000;
    if (grant_en) begin
      if (elig[2])      gnt = 3'b100;
      else if (elig[0]) gnt = 3'b001;
      else if (elig[1]) gnt = 3'b010;
    end
  end
`else
  logic [1:0] ptr_q;  // class index that has first pick
  logic       found;
  int         idx;

  always_comb begin
    gnt   = 3'b000;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(ptr_q) + i) % 3;
      if (grant_en && !found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (gnt[0]) begin
      ptr_q <= 2'd1;
    end else if (gnt[1]) begin
      ptr_q <= 2'd2;
    end else if (gnt[2]) begin
      ptr_q <= 2'd0;
    end
  end
`endif

endmodule

// File: rtl/tl_tx_arbiter.sv
// TX TLP scheduler: picks P/NP/CPL against credits and retry space, then sequences header
// and payload pops onto the 256-bit DLL stream. TL_TX_ARB_STRICT_PRIO_EN selects fixed priority.
module tl_tx_arbiter import tl_pkg::*; #(
  parameter int unsigned MPS_DW          = 32,
  parameter int unsigned RETRY_DEPTH_LG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       link_active_i,
  input  logic                       p_hdr_empty_i,
  input  logic                       np_hdr_empty_i,
  input  logic                       cpl_hdr_empty_i,
  input  logic [127:0]               p_hdr_rdata_i,
  input  logic [127:0]               np_hdr_rdata_i,
  input  logic [95:0]                cpl_hdr_rdata_i,
  input  logic [255:0]               p_data_rdata_i,
  input  logic [255:0]               cpl_data_rdata_i,
  output logic                       p_hdr_rden_o,
  output logic                       np_hdr_rden_o,
  output logic                       cpl_hdr_rden_o,
  output logic                       p_data_rden_o,
  output logic                       cpl_data_rden_o,
  input  logic [3:0]                 p_payload_cnt_i,
  input  logic [3:0]                 cpl_payload_cnt_i,
  output logic                       p_sent_o,
  output logic                       cpl_sent_o,
  input  logic [11:0]                ph_avail_i,
  input  logic [11:0]                pd_avail_i,
  input  logic [11:0]                nh_avail_i,
  input  logic [11:0]                ch_avail_i,
  input  logic [11:0]                cd_avail_i,
  input  logic [RETRY_DEPTH_LG2+2:0] retry_leftover_i,
  output logic [255:0]               tlp_o,
  output logic [2:0]                 req_o
);

  localparam int unsigned BeatW = $clog2(MPS_DW / 8 + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_t;

  state_t           state_q;
  cls_t             cls_q;
  logic [BeatW-1:0] beats_q;

  logic             p_has, cpl_has;
  logic [9:0]       p_len, cpl_len;
  logic [7:0]       p_beats, cpl_beats;
  logic [2:0]       elig, gnt;
  logic             grant_en;
  cls_t             gnt_cls;
  logic [BeatW-1:0] gnt_beats;
  logic [255:0]     hdr_beat, data_beat;
  req_t             hdr_req, data_req;

  // Eligibility only feeds the grant registers, never the pop strobes.
  always_comb begin
    p_len     = p_hdr_rdata_i[HdrLenLsb +: HdrLenW];
    cpl_len   = cpl_hdr_rdata_i[HdrLenLsb +: HdrLenW];
    p_has     = p_hdr_rdata_i[HdrHasDataBit];
    cpl_has   = cpl_hdr_rdata_i[HdrHasDataBit];
    p_beats   = p_has ? beats_of(p_len) : 8'd0;
    cpl_beats = cpl_has ? beats_of(cpl_len) : 8'd0;

    elig[0] = link_active_i && !p_hdr_empty_i && (ph_avail_i != 12'd0) &&
              (!p_has || ((32'(pd_avail_i) >= 32'(credits_of(p_len))) &&
                          (p_payload_cnt_i != 4'd0))) &&
              (32'(retry_leftover_i) >= 32'd4 + (32'(p_beats) << 3));
    elig[1] = link_active_i && !np_hdr_empty_i && (nh_avail_i != 12'd0) &&
              (32'(retry_leftover_i) >= 32'd4);
    elig[2] = link_active_i && !cpl_hdr_empty_i && (ch_avail_i != 12'd0) &&
              (!cpl_has || ((32'(cd_avail_i) >= 32'(credits_of(cpl_len))) &&
                            (cpl_payload_cnt_i != 4'd0))) &&
              (32'(retry_leftover_i) >= 32'd4 + (32'(cpl_beats) << 3));
  end

  assign grant_en = (state_q == StIdle);

  tl_rr_arb3 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .elig     (elig),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_comb begin
    gnt_cls   = ClsP;
    gnt_beats = '0;
    if (gnt[2]) begin
      gnt_cls   = ClsCpl;
      gnt_beats = BeatW'(cpl_beats);
    end else if (gnt[1]) begin
      gnt_cls   = ClsNp;
    end else if (gnt[0]) begin
      gnt_beats = BeatW'(p_beats);
    end
  end

  always_comb begin
    hdr_beat  = '0;
    data_beat = '0;
    hdr_req   = ReqIdle;
    data_req  = ReqIdle;
    case (cls_q)
      ClsP: begin
        hdr_beat  = {128'd0, p_hdr_rdata_i};
        data_beat = p_data_rdata_i;
        hdr_req   = ReqPHdr;
        data_req  = ReqPData;
      end
      ClsNp: begin
        hdr_beat  = {128'd0, np_hdr_rdata_i};
        hdr_req   = ReqNpHdr;
      end
      ClsCpl: begin
        hdr_beat  = {160'd0, cpl_hdr_rdata_i};
        data_beat = cpl_data_rdata_i;
        hdr_req   = ReqCplHdr;
        data_req  = ReqCplData;
      end
      default: ;
    endcase
  end

  assign p_hdr_rden_o    = (state_q == StHdr)  && (cls_q == ClsP);
  assign np_hdr_rden_o   = (state_q == StHdr)  && (cls_q == ClsNp);
  assign cpl_hdr_rden_o  = (state_q == StHdr)  && (cls_q == ClsCpl);
  assign p_data_rden_o   = (state_q == StData) && (cls_q == ClsP);
  assign cpl_data_rden_o = (state_q == StData) && (cls_q == ClsCpl);

  // The beat is captured from the FWFT head on the same edge that pops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cls_q      <= ClsP;
      beats_q    <= '0;
      tlp_o      <= '0;
      req_o      <= ReqIdle;
      p_sent_o   <= 1'b0;
      cpl_sent_o <= 1'b0;
    end else begin
      tlp_o      <= '0;
      req_o      <= ReqIdle;
      p_sent_o   <= 1'b0;
      cpl_sent_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|gnt) begin
            cls_q   <= gnt_cls;
            beats_q <= gnt_beats;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          tlp_o   <= hdr_beat;
          req_o   <= hdr_req;
          state_q <= (beats_q != '0) ? StData : StIdle;
        end
        StData: begin
          tlp_o   <= data_beat;
          req_o   <= data_req;
          beats_q <= beats_q - BeatW'(1);
          if (beats_q == BeatW'(1)) begin
            p_sent_o   <= (cls_q == ClsP);
            cpl_sent_o <= (cls_q == ClsCpl);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Scoreboard bench for tl_tx_arbiter: stimulus queues expected beats, a negedge monitor
// pops and compares every beat the DUT presents.
module tb_tl_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         link_active;
  logic         p_hdr_empty, np_hdr_empty, cpl_hdr_empty;
  logic [127:0] p_hdr, np_hdr;
  logic [95:0]  cpl_hdr;
  logic [255:0] p_data, cpl_data;
  logic         p_hdr_rden, np_hdr_rden, cpl_hdr_rden, p_data_rden, cpl_data_rden;
  logic [3:0]   p_payload_cnt, cpl_payload_cnt;
  logic         p_sent, cpl_sent;
  logic [11:0]  ph_avail, pd_avail, nh_avail, ch_avail, cd_avail;
  logic [10:0]  retry_leftover;
  logic [255:0] tlp;
  logic [2:0]   req;

  int total = 0;
  int bad = 0;

  // FIFO model: stimulus owns the push counts, the model owns the pop counts.
  int p_push = 0, np_push = 0, cpl_push = 0;
  int p_hpop = 0, np_hpop = 0, cpl_hpop = 0, p_dpop = 0, cpl_dpop = 0;
  int p_sent_n = 0, cpl_sent_n = 0;
  int exp_pd = 0, exp_cd = 0;

  typedef struct {
    logic [2:0]   req;
    logic [255:0] tlp;
    logic [1:0]   sent;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  assign p_hdr_empty     = (p_push == p_hpop);
  assign np_hdr_empty    = (np_push == np_hpop);
  assign cpl_hdr_empty   = (cpl_push == cpl_hpop);
  assign p_payload_cnt   = 4'(p_push - p_hpop);
  assign cpl_payload_cnt = 4'(cpl_push - cpl_hpop);
  assign p_data          = {8{32'hDA00_0000 ^ 32'(p_dpop)}};
  assign cpl_data        = {8{32'hC0DE_0000 ^ 32'(cpl_dpop)}};

  tl_tx_arbiter #(
    .MPS_DW          (32),
    .RETRY_DEPTH_LG2 (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .link_active_i     (link_active),
    .p_hdr_empty_i     (p_hdr_empty),
    .np_hdr_empty_i    (np_hdr_empty),
    .cpl_hdr_empty_i   (cpl_hdr_empty),
    .p_hdr_rdata_i     (p_hdr),
    .np_hdr_rdata_i    (np_hdr),
    .cpl_hdr_rdata_i   (cpl_hdr),
    .p_data_rdata_i    (p_data),
    .cpl_data_rdata_i  (cpl_data),
    .p_hdr_rden_o      (p_hdr_rden),
    .np_hdr_rden_o     (np_hdr_rden),
    .cpl_hdr_rden_o    (cpl_hdr_rden),
    .p_data_rden_o     (p_data_rden),
    .cpl_data_rden_o   (cpl_data_rden),
    .p_payload_cnt_i   (p_payload_cnt),
    .cpl_payload_cnt_i (cpl_payload_cnt),
    .p_sent_o          (p_sent),
    .cpl_sent_o        (cpl_sent),
    .ph_avail_i        (ph_avail),
    .pd_avail_i        (pd_avail),
    .nh_avail_i        (nh_avail),
    .ch_avail_i        (ch_avail),
    .cd_avail_i        (cd_avail),
    .retry_leftover_i  (retry_leftover),
    .tlp_o             (tlp),
    .req_o             (req)
  );

  always @(posedge clk) begin
    if (p_hdr_rden)    p_hpop     <= p_hpop + 1;
    if (np_hdr_rden)   np_hpop    <= np_hpop + 1;
    if (cpl_hdr_rden)  cpl_hpop   <= cpl_hpop + 1;
    if (p_data_rden)   p_dpop     <= p_dpop + 1;
    if (cpl_data_rden) cpl_dpop   <= cpl_dpop + 1;
    if (p_sent)        p_sent_n   <= p_sent_n + 1;
    if (cpl_sent)      cpl_sent_n <= cpl_sent_n + 1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && (req != 3'd0 || p_sent || cpl_sent)) begin
      if (sb.size() == 0) begin
        check("spurious beat {req,p_sent,cpl_sent}", 256'({req, p_sent, cpl_sent}), 256'd0);
      end else begin
        e = sb.pop_front();
        check("beat req", 256'(req), 256'(e.req));
        check("beat tlp", tlp, e.tlp);
        check("beat {p_sent,cpl_sent}", 256'({p_sent, cpl_sent}), 256'(e.sent));
      end
    end
  end

  function automatic logic [127:0] mk_p(input logic [9:0] len, input logic has);
    return {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 1'b0, has, 20'd0, len};
  endfunction

  function automatic logic [95:0] mk_cpl(input logic [9:0] len, input logic has);
    return {32'hCCCC_0001, 32'hCCCC_0002, 1'b0, has, 20'd0, len};
  endfunction

  // cls: 0 = P, 1 = NP, 2 = CPL
  task automatic exp_tlp(input int cls, input int beats);
    beat_t b;
    b.req  = (cls == 0) ? 3'd1 : (cls == 1) ? 3'd3 : 3'd5;
    b.tlp  = (cls == 0) ? {128'd0, p_hdr} : (cls == 1) ? {128'd0, np_hdr} : {160'd0, cpl_hdr};
    b.sent = 2'b00;
    sb.push_back(b);
    for (int i = 0; i < beats; i++) begin
      b.req = (cls == 0) ? 3'd2 : 3'd6;
      if (cls == 0) begin
        b.tlp = {8{32'hDA00_0000 ^ 32'(exp_pd)}};
        exp_pd++;
      end else begin
        b.tlp = {8{32'hC0DE_0000 ^ 32'(exp_cd)}};
        exp_cd++;
      end
      b.sent = (i == beats - 1) ? ((cls == 0) ? 2'b10 : 2'b01) : 2'b00;
      sb.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(name, 256'(sb.size()), 256'd0);
    sb.delete();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // One P, NP and CPL (Len 8) pushed together; expected grant order depends on the build.
  task automatic round3(input string name);
    p_hdr   = mk_p(10'd8, 1'b1);
    cpl_hdr = mk_cpl(10'd8, 1'b1);
`ifdef TL_TX_ARB_STRICT_PRIO_EN
    exp_tlp(2, 1);
    exp_tlp(0, 1);
    exp_tlp(1, 0);
`else
    exp_tlp(0, 1);
    exp_tlp(1, 0);
    exp_tlp(2, 1);
`endif
    p_push++;
    np_push++;
    cpl_push++;
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, d0, s0, n;
    link_active    = 1'b1;
    ph_avail       = 12'h0FF;
    pd_avail       = 12'h0FF;
    nh_avail       = 12'h0FF;
    ch_avail       = 12'h0FF;
    cd_avail       = 12'h0FF;
    retry_leftover = 11'd100;
    p_hdr          = mk_p(10'd8, 1'b1);
    np_hdr         = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'h0000_0001};
    cpl_hdr        = mk_cpl(10'd8, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    check("reset tlp_o", tlp, 256'd0);
    check("reset req_o", 256'(req), 256'd0);
    check("reset sent", 256'({p_sent, cpl_sent}), 256'd0);
    check("reset rden", 256'({p_hdr_rden, np_hdr_rden, cpl_hdr_rden, p_data_rden, cpl_data_rden}),
          256'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 3; r++) round3("arbitration round drained");

    // P Len 16 with exactly 4 data credits: 1 header pop, 2 data pops, 1 sent pulse.
    p_hdr    = mk_p(10'd16, 1'b1);
    pd_avail = 12'd4;
    h0 = p_hpop; d0 = p_dpop; s0 = p_sent_n;
    exp_tlp(0, 2);
    p_push++;
    wait_drain("P len16 drained");
    check("P len16 hdr pops", 256'(p_hpop - h0), 256'd1);
    check("P len16 data pops", 256'(p_dpop - d0), 256'd2);
    check("P len16 sent pulses", 256'(p_sent_n - s0), 256'd1);

    // P Len 32 needs 8 data credits; 7 stalls it while NP proceeds.
    p_hdr    = mk_p(10'd32, 1'b1);
    pd_avail = 12'd7;
    h0 = p_hpop;
    exp_tlp(1, 0);
    exp_tlp(1, 0);
    p_push++;
    np_push += 2;
    wait_drain("NP past credit-stalled P drained");
    check("P stalled on pd credit", 256'(p_hpop - h0), 256'd0);
    pd_avail = 12'd8;
    exp_tlp(0, 4);
    wait_drain("P after credit raise drained");
    check("P granted after credit raise", 256'(p_hpop - h0), 256'd1);

    // Retry space: Len 32 needs 4 + 8*4 = 36 DW.
    pd_avail       = 12'h0FF;
    retry_leftover = 11'd35;
    h0 = p_hpop;
    p_push++;
    repeat (20) @(posedge clk);
    #1;
    check("P stalled on retry 35", 256'(p_hpop - h0), 256'd0);
    retry_leftover = 11'd36;
    exp_tlp(0, 4);
    wait_drain("P with retry 36 drained");
    check("P granted at retry 36", 256'(p_hpop - h0), 256'd1);
    retry_leftover = 11'd100;

    // CPL without data, Length field 0.
    cpl_hdr = mk_cpl(10'd0, 1'b0);
    h0 = cpl_hpop; d0 = cpl_dpop; s0 = cpl_sent_n;
    exp_tlp(2, 0);
    cpl_push++;
    wait_drain("CPL no-data drained");
    check("CPL no-data hdr pops", 256'(cpl_hpop - h0), 256'd1);
    check("CPL no-data data pops", 256'(cpl_dpop - d0), 256'd0);
    check("CPL no-data sent pulses", 256'(cpl_sent_n - s0), 256'd0);

    // Reset while the second data beat of a P Len 16 is being popped.
    p_hdr = mk_p(10'd16, 1'b1);
    exp_tlp(0, 2);
    void'(sb.pop_back());
    p_push++;
    n = 0;
    while (req != 3'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached first P data beat", 256'(req), 256'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async reset tlp_o", tlp, 256'd0);
    check("async reset req_o", 256'(req), 256'd0);
    check("async reset sent", 256'({p_sent, cpl_sent}), 256'd0);
    check("async reset rden", 256'({p_hdr_rden, np_hdr_rden, cpl_hdr_rden, p_data_rden,
                                     cpl_data_rden}), 256'd0);
    check("beats before reset seen", 256'(sb.size()), 256'd0);
    sb.delete();
    exp_pd = p_dpop;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle after reset release", 256'(req), 256'd0);
    round3("post-reset round drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
